// File: rtl/muon_trace_capture_pkg.sv
// Shared constants and types for the muon trace capture block.
// Defaults, header tag and drop counter helpers.
package muon_trace_capture_pkg;

   localparam int MUON_CAPT_PRE_DEFAULT    = 4;
   localparam int MUON_CAPT_POST_DEFAULT   = 12;
   localparam int MUON_CAPT_NSLOTS_DEFAULT = 4;
   localparam int MUON_CAPT_DROP_WIDTH     = 16;

   localparam logic [3:0] MUON_CAPT_HDR_TAG = 4'hA;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CAPT = 1'b1
   } capt_state_t;

   typedef logic [MUON_CAPT_DROP_WIDTH-1:0] drop_cnt_t;

   function automatic drop_cnt_t drop_inc(input drop_cnt_t c);
      return (&c) ? c : c + 1'b1;
   endfunction

endpackage

// File: rtl/muon_capt_ram.sv
// Simple dual-port event memory: one write port, one registered read port.
// Read data holds while the read enable is low.
module muon_capt_ram #(
   parameter int DW = 48,
   parameter int AW = 7
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/muon_trace_capture.sv
// Muon trace capture: delays ADC streams, captures pre/post trigger
// windows into event slots and streams complete events out.
module muon_trace_capture
   import muon_trace_capture_pkg::*;
#(
   parameter int ADC_WIDTH = 12,
   parameter int PRE       = MUON_CAPT_PRE_DEFAULT,
   parameter int POST      = MUON_CAPT_POST_DEFAULT,
   parameter int NSLOTS    = MUON_CAPT_NSLOTS_DEFAULT,
   parameter int TS_WIDTH  = 32
) (
   input  logic                            CLK120,
   input  logic                            RESET_N,
   input  logic [ADC_WIDTH-1:0]            ADC0,
   input  logic [ADC_WIDTH-1:0]            ADC1,
   input  logic [ADC_WIDTH-1:0]            ADC2,
   input  logic [ADC_WIDTH-1:0]            ADC_SSD,
   input  logic                            TRIG,
   input  logic                            CAPTURE_ENAB,
   output logic [4*ADC_WIDTH-1:0]          RD_DATA,
   output logic                            RD_VALID,
   input  logic                            RD_READY,
   output logic                            RD_LAST,
   output logic [$clog2(NSLOTS):0]         NFULL,
   output logic [MUON_CAPT_DROP_WIDTH-1:0] DROP_CNT
);

   localparam int DW    = 4*ADC_WIDTH;
   localparam int NWORD = 1 + PRE + POST;
   localparam int IW    = $clog2(NWORD);
   localparam int SW    = $clog2(NSLOTS);
   localparam int AW    = SW + IW;
   localparam int NW    = SW + 1;

   localparam logic [IW-1:0] LAST_IDX = IW'(PRE + POST);
   localparam logic [NW-1:0] FULL     = NW'(NSLOTS);

   logic [DW-1:0]       r_s;
   logic [DW-1:0]       r_dly [PRE];
   logic [TS_WIDTH-1:0] r_ts;

   capt_state_t         r_state;
   logic [IW-1:0]       r_widx;
   logic [SW-1:0]       r_wptr;
   logic [NW-1:0]       r_nfull;
   drop_cnt_t           r_drop;

   logic                r_ropen;
   logic                r_iss;
   logic [IW-1:0]       r_ridx;
   logic [SW-1:0]       r_rptr;
   logic                r_p_vld;
   logic                r_p_last;
   logic                r_vld;
   logic                r_last;
   logic [DW-1:0]       r_data;

   logic                w_trig;
   logic                w_cap_start;
   logic                w_cap_done;
   logic                w_drop;
   logic                w_we;
   logic [IW-1:0]       w_widx;
   logic [AW-1:0]       w_waddr;
   logic [DW-1:0]       w_hdr;
   logic [DW-1:0]       w_wdata;
   logic                w_acc;
   logic                w_rd_done;
   logic                w_load;
   logic                w_issue;
   logic                w_start;
   logic [AW-1:0]       w_raddr;
   logic [DW-1:0]       w_q;

   // Input register plus PRE-deep delay so the window starts before TRIG
   always_ff @(posedge CLK120 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_s <= '0;
         for (int i = 0; i < PRE; i++) r_dly[i] <= '0;
      end else begin
         r_s      <= {ADC_SSD, ADC2, ADC1, ADC0};
         r_dly[0] <= r_s;
         for (int i = 1; i < PRE; i++) r_dly[i] <= r_dly[i-1];
      end
   end

   assign w_trig      = TRIG && CAPTURE_ENAB;
   assign w_cap_start = w_trig && (r_state == ST_IDLE) && (r_nfull != FULL);
   assign w_cap_done  = (r_state == ST_CAPT) && (r_widx == LAST_IDX);
   assign w_drop      = w_trig && !w_cap_start;
   assign w_we        = w_cap_start || (r_state == ST_CAPT);

   always_comb begin
      w_hdr                 = '0;
      w_hdr[DW-1 -: 4]      = MUON_CAPT_HDR_TAG;
      w_hdr[TS_WIDTH-1:0]   = r_ts;
      w_widx                = (r_state == ST_CAPT) ? r_widx : '0;
      w_wdata               = (r_state == ST_CAPT) ? r_dly[PRE-1] : w_hdr;
   end

   assign w_waddr = {r_wptr, w_widx};

   always_ff @(posedge CLK120 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_ts    <= '0;
         r_state <= ST_IDLE;
         r_widx  <= '0;
         r_wptr  <= '0;
         r_drop  <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (w_drop) r_drop <= drop_inc(r_drop);
         unique case (r_state)
            ST_IDLE: begin
               if (w_cap_start) begin
                  r_state <= ST_CAPT;
                  r_widx  <= IW'(1);
               end
            end
            ST_CAPT: begin
               if (w_cap_done) begin
                  r_state <= ST_IDLE;
                  r_widx  <= '0;
                  r_wptr  <= r_wptr + 1'b1;
               end else begin
                  r_widx  <= r_widx + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Simultaneous complete and free leave the count unchanged
   always_ff @(posedge CLK120 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_nfull <= '0;
      end else if (w_cap_done && !w_rd_done) begin
         r_nfull <= r_nfull + 1'b1;
      end else if (!w_cap_done && w_rd_done) begin
         r_nfull <= r_nfull - 1'b1;
      end
   end

   muon_capt_ram #(
      .DW(DW),
      .AW(AW)
   ) u_ram (
      .i_clk   (CLK120),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_issue),
      .i_raddr (w_raddr),
      .o_rdata (w_q)
   );

   // Two-deep read pipe: RAM output stage feeds the output register
   assign w_acc     = r_vld && RD_READY;
   assign w_rd_done = w_acc && r_last;
   assign w_load    = r_p_vld && (!r_vld || w_acc);
   assign w_issue   = r_iss && (!r_p_vld || w_load);
   assign w_start   = !r_ropen && (r_nfull != '0);
   assign w_raddr   = {r_rptr, r_ridx};

   always_ff @(posedge CLK120 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_ropen  <= 1'b0;
         r_iss    <= 1'b0;
         r_ridx   <= '0;
         r_rptr   <= '0;
         r_p_vld  <= 1'b0;
         r_p_last <= 1'b0;
         r_vld    <= 1'b0;
         r_last   <= 1'b0;
         r_data   <= '0;
      end else begin
         if (w_start) begin
            r_ropen <= 1'b1;
            r_iss   <= 1'b1;
            r_ridx  <= '0;
         end
         if (w_issue) begin
            r_p_last <= (r_ridx == LAST_IDX);
            if (r_ridx == LAST_IDX) r_iss <= 1'b0;
            else r_ridx <= r_ridx + 1'b1;
         end
         if (w_issue) r_p_vld <= 1'b1;
         else if (w_load) r_p_vld <= 1'b0;
         if (w_load) begin
            r_vld  <= 1'b1;
            r_last <= r_p_last;
            r_data <= w_q;
         end else if (w_acc) begin
            r_vld  <= 1'b0;
            r_last <= 1'b0;
         end
         if (w_rd_done) begin
            r_ropen <= 1'b0;
            r_rptr  <= r_rptr + 1'b1;
         end
      end
   end

   assign RD_DATA  = r_data;
   assign RD_VALID = r_vld;
   assign RD_LAST  = r_last;
   assign NFULL    = r_nfull;
   assign DROP_CNT = r_drop;

endmodule

// File: tb/tb_muon_trace_capture.sv
// Bench for muon_trace_capture: directed and random triggers checked
// against a window/slot reference model and a word scoreboard.
module tb_muon_trace_capture;

   localparam int PRE    = 4;
   localparam int POST   = 12;
   localparam int NSLOTS = 4;
   localparam int HSZ    = 4096;

   logic        clk = 1'b0;
   logic        RESET_N;
   logic [11:0] ADC0, ADC1, ADC2, ADC_SSD;
   logic        TRIG, CAPTURE_ENAB;
   logic [47:0] RD_DATA;
   logic        RD_VALID, RD_READY, RD_LAST;
   logic [2:0]  NFULL;
   logic [15:0] DROP_CNT;

   always #5 clk = ~clk;

   muon_trace_capture #(
      .ADC_WIDTH(12), .PRE(PRE), .POST(POST),
      .NSLOTS(NSLOTS), .TS_WIDTH(32)
   ) dut (
      .CLK120(clk), .RESET_N(RESET_N),
      .ADC0(ADC0), .ADC1(ADC1), .ADC2(ADC2), .ADC_SSD(ADC_SSD),
      .TRIG(TRIG), .CAPTURE_ENAB(CAPTURE_ENAB),
      .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
      .RD_LAST(RD_LAST), .NFULL(NFULL), .DROP_CNT(DROP_CNT)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc;
   logic [47:0] hist [HSZ];
   logic [47:0] exp_q [$];
   bit          el_q [$];
   int          m_nfull, m_drop, m_t, n_words;
   bit          m_cap;
   int          rdy_mode;
   logic        rdy_val;
   bit          prev_stall;
   logic [47:0] prev_data;
   logic        prev_last;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      ADC0    = cyc[11:0];
      ADC1    = 12'($urandom);
      ADC2    = 12'($urandom);
      ADC_SSD = 12'($urandom);
      hist[cyc % HSZ] = {ADC_SSD, ADC2, ADC1, ADC0};
      case (rdy_mode)
         0:       RD_READY = rdy_val;
         1:       RD_READY = !RD_READY;
         default: RD_READY = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic push_event(input int t);
      exp_q.push_back({4'hA, 12'h000, 32'(t)});
      el_q.push_back(1'b0);
      for (int k = 0; k < PRE + POST; k++) begin
         exp_q.push_back(hist[((t - PRE + k) % HSZ + HSZ) % HSZ]);
         el_q.push_back(k == PRE + POST - 1);
      end
   endtask

   task automatic tick();
      logic [47:0] ew;
      bit          el, rd_done, cap_done;
      @(negedge clk);
      chk("nfull", 64'(NFULL), 64'(m_nfull));
      chk("drop_cnt", 64'(DROP_CNT), 64'(m_drop));
      if (prev_stall) begin
         chk("hold_valid", 64'(RD_VALID), 64'(1));
         chk("hold_data", 64'(RD_DATA), 64'(prev_data));
         chk("hold_last", 64'(RD_LAST), 64'(prev_last));
      end
      prev_stall = RD_VALID && !RD_READY;
      prev_data  = RD_DATA;
      prev_last  = RD_LAST;
      rd_done  = 1'b0;
      cap_done = 1'b0;
      if (RD_VALID && RD_READY) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 64'(RD_VALID), 64'(0));
         end else begin
            ew = exp_q.pop_front();
            el = el_q.pop_front();
            chk("rd_data", 64'(RD_DATA), 64'(ew));
            chk("rd_last", 64'(RD_LAST), 64'(el));
            n_words++;
            rd_done = el;
         end
      end
      if (TRIG && CAPTURE_ENAB) begin
         if (m_cap || m_nfull == NSLOTS) begin
            if (m_drop < 65535) m_drop++;
         end else begin
            m_cap = 1'b1;
            m_t   = cyc;
         end
      end
      if (m_cap && cyc == m_t + PRE + POST) begin
         push_event(m_t);
         m_cap    = 1'b0;
         cap_done = 1'b1;
      end
      m_nfull = m_nfull + int'(cap_done) - int'(rd_done);
      @(posedge clk);
      cyc++;
      #1;
      drive();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic trig_pulse();
      TRIG = 1'b1;
      tick();
      TRIG = 1'b0;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      RESET_N    = 1'b1;
      cyc        = 0;
      m_nfull    = 0;
      m_drop     = 0;
      m_cap      = 1'b0;
      prev_stall = 1'b0;
      TRIG       = 1'b0;
      exp_q.delete();
      el_q.delete();
      drive();
   endtask

   initial begin
      RESET_N      = 1'b0;
      TRIG         = 1'b0;
      CAPTURE_ENAB = 1'b1;
      RD_READY     = 1'b0;
      rdy_mode     = 0;
      rdy_val      = 1'b0;
      cyc          = 0;
      n_words      = 0;
      ADC0 = '0; ADC1 = '0; ADC2 = '0; ADC_SSD = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(RD_VALID), 64'(0));
      chk("rst_last", 64'(RD_LAST), 64'(0));
      chk("rst_data", 64'(RD_DATA), 64'(0));
      chk("rst_nfull", 64'(NFULL), 64'(0));
      chk("rst_drop", 64'(DROP_CNT), 64'(0));
      release_reset();

      // single trigger at count 100, ready held high
      rdy_val = 1'b1;
      wait_until(100);
      trig_pulse();
      run(60);
      chk("t1_words", 64'(n_words), 64'(17));

      // fill all slots with the reader stalled, then drain
      rdy_val = 1'b0;
      for (int i = 0; i < 6; i++) begin
         trig_pulse();
         run(39);
      end
      chk("t2_nfull", 64'(NFULL), 64'(4));
      chk("t2_drop", 64'(DROP_CNT), 64'(2));
      rdy_val = 1'b1;
      run(100);
      chk("t2_words", 64'(n_words), 64'(17 * 5));

      // second trigger during capture is dropped
      trig_pulse();
      run(4);
      trig_pulse();
      run(60);
      chk("t3_drop", 64'(DROP_CNT), 64'(3));
      chk("t3_words", 64'(n_words), 64'(17 * 6));

      // ready toggling every cycle
      rdy_mode = 1;
      trig_pulse();
      run(80);
      chk("t4_words", 64'(n_words), 64'(17 * 7));

      // random triggers, enables and backpressure
      rdy_mode = 2;
      repeat (1500) begin
         TRIG         = ($urandom_range(0, 19) == 0);
         CAPTURE_ENAB = ($urandom_range(0, 7) != 0);
         tick();
      end
      TRIG         = 1'b0;
      CAPTURE_ENAB = 1'b1;
      rdy_mode     = 0;
      rdy_val      = 1'b1;
      run(150);
      chk("t5_drained", 64'(exp_q.size()), 64'(0));

      // asynchronous reset with one event pending and one in capture
      rdy_val = 1'b0;
      trig_pulse();
      run(40);
      trig_pulse();
      run(5);
      #3;
      RESET_N = 1'b0;
      #1;
      chk("arst_valid", 64'(RD_VALID), 64'(0));
      chk("arst_last", 64'(RD_LAST), 64'(0));
      chk("arst_data", 64'(RD_DATA), 64'(0));
      chk("arst_nfull", 64'(NFULL), 64'(0));
      chk("arst_drop", 64'(DROP_CNT), 64'(0));
      release_reset();
      rdy_val = 1'b1;
      n_words = 0;
      wait_until(50);
      trig_pulse();
      run(60);
      chk("t6_words", 64'(n_words), 64'(17));

      // disabled capture ignores triggers
      CAPTURE_ENAB = 1'b0;
      for (int i = 0; i < 5; i++) begin
         trig_pulse();
         run(10);
      end
      chk("t7_drop", 64'(DROP_CNT), 64'(0));
      chk("t7_nfull", 64'(NFULL), 64'(0));
      chk("t7_words", 64'(n_words), 64'(17));
      CAPTURE_ENAB = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
